// File: rtl/buzzer_arbiter_pkg.sv
// Shared types and constants for the buzzer arbiter and its button conditioning.
package buzzer_arbiter_pkg;

  localparam int NUM_BTN = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    LOCKED = 3'd2,
    FAULT  = 3'd3,
    REARM  = 3'd4
  } state_e;

  // Number of simultaneous rising edges; ARMED needs exactly one to pick a winner.
  function automatic logic [2:0] count_ones(input logic [NUM_BTN-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_BTN; i++) n = n + 3'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, debounced level and rise pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// First-press arbiter in front of the one-hot decoder: conditions buttons, picks one winner.
module buzzer_arbiter
  import buzzer_arbiter_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int LOCK_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               arm,
  input  logic               clear,
  output logic [NUM_BTN-1:0] btn_out,
  output logic               invalid,
  output logic               armed,
  output logic               locked
);

  localparam int LW = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

  logic [NUM_BTN-1:0] level, rise;
  logic               all_low;
  logic [2:0]         rise_n;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .btn_raw_i(btn_raw[i]),
      .level_o  (level[i]),
      .rise_o   (rise[i])
    );
  end

  assign all_low = ~|level;
  assign rise_n  = count_ones(rise);

  state_e             state_q, state_d;
  logic [NUM_BTN-1:0] btn_out_q, btn_out_d;
  logic [LW-1:0]      lock_cnt_q, lock_cnt_d;
  logic               lock_done;

  assign lock_done = (LOCK_CYCLES > 0) && (lock_cnt_q == LW'(LOCK_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    btn_out_d  = '0;
    lock_cnt_d = '0;
    case (state_q)
      IDLE:   if (arm) state_d = all_low ? ARMED : REARM;
      REARM:  if (clear) state_d = IDLE;
              else if (all_low) state_d = ARMED;
      ARMED:  if (clear) state_d = IDLE;
              else if (rise_n == 3'd1) begin
                state_d   = LOCKED;
                btn_out_d = rise;
              end else if (rise_n > 3'd1) state_d = FAULT;
      LOCKED: if (clear) state_d = IDLE;
              else if (lock_done) state_d = REARM;
              else begin
                btn_out_d  = btn_out_q;
                lock_cnt_d = (LOCK_CYCLES > 0) ? lock_cnt_q + LW'(1) : '0;
              end
      FAULT:  if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      btn_out_q  <= '0;
      lock_cnt_q <= '0;
      invalid    <= 1'b1;
      armed      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_out_q  <= btn_out_d;
      lock_cnt_q <= lock_cnt_d;
      invalid    <= !(state_d == ARMED || state_d == LOCKED);
      armed      <= (state_d == ARMED);
      locked     <= (state_d == LOCKED);
    end
  end

  assign btn_out = btn_out_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter: one instance with hold-until-clear, one with a 5-cycle lock.
module tb_buzzer_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = '0, btn_raw1 = '0;
  logic       arm = 1'b0, arm1 = 1'b0, clear = 1'b0, clear1 = 1'b0;
  logic [3:0] btn_out, btn_out1;
  logic       invalid, armed, locked, invalid1, armed1, locked1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  buzzer_arbiter #(.DEB_CYCLES(4), .LOCK_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .arm(arm), .clear(clear),
    .btn_out(btn_out), .invalid(invalid), .armed(armed), .locked(locked)
  );

  buzzer_arbiter #(.DEB_CYCLES(4), .LOCK_CYCLES(5)) dut1 (
    .clk(clk), .rst(rst), .btn_raw(btn_raw1), .arm(arm1), .clear(clear1),
    .btn_out(btn_out1), .invalid(invalid1), .armed(armed1), .locked(locked1)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_btn_out", btn_out, 4'b0000);
    check("rst_invalid", 4'(invalid), 4'd1);
    check("rst_armed", 4'(armed), 4'd0);
    check("rst_locked", 4'(locked), 4'd0);

    // Arm with buttons released
    arm = 1'b1; tick(1); arm = 1'b0;
    check("arm_armed", 4'(armed), 4'd1);
    check("arm_invalid", 4'(invalid), 4'd0);

    // Single press: winner exactly 7 edges after the raw change
    btn_raw = 4'b0100;
    tick(6);
    check("win_early_btn", btn_out, 4'b0000);
    check("win_early_locked", 4'(locked), 4'd0);
    tick(1);
    check("win_btn", btn_out, 4'b0100);
    check("win_locked", 4'(locked), 4'd1);
    check("win_invalid", 4'(invalid), 4'd0);
    btn_raw = 4'b0101;
    tick(10);
    check("late_press_ignored", btn_out, 4'b0100);

    // clear -> IDLE
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clr_btn", btn_out, 4'b0000);
    check("clr_invalid", 4'(invalid), 4'd1);
    check("clr_locked", 4'(locked), 4'd0);

    // Simultaneous press -> FAULT
    btn_raw = 4'b0000; tick(8);
    arm = 1'b1; tick(1); arm = 1'b0;
    check("rearm_armed", 4'(armed), 4'd1);
    btn_raw = 4'b1010;
    tick(6);
    check("fault_early_armed", 4'(armed), 4'd1);
    tick(1);
    check("fault_btn", btn_out, 4'b0000);
    check("fault_invalid", 4'(invalid), 4'd1);
    check("fault_armed", 4'(armed), 4'd0);
    check("fault_locked", 4'(locked), 4'd0);
    btn_raw = 4'b0000; tick(8);
    arm = 1'b1; tick(1); arm = 1'b0;
    check("fault_arm_ignored", 4'(armed), 4'd0);
    clear = 1'b1; tick(1); clear = 1'b0;
    arm = 1'b1; tick(1); arm = 1'b0;
    check("fault_clear_arm", 4'(armed), 4'd1);

    // Bounce on bit 1: stable from the 9th setting onward
    for (int i = 0; i < 10; i++) begin
      btn_raw = {2'b00, ~i[1], 1'b0};
      tick(1);
    end
    tick(4);
    check("bounce_quiet", btn_out, 4'b0000);
    tick(1);
    check("bounce_win", btn_out, 4'b0010);

    // Arm while a button is held -> REARM, then ARMED after release
    clear = 1'b1; btn_raw = 4'b0001; tick(1); clear = 1'b0;
    tick(8);
    arm = 1'b1; tick(1); arm = 1'b0;
    check("held_armed", 4'(armed), 4'd0);
    check("held_invalid", 4'(invalid), 4'd1);
    btn_raw = 4'b0000;
    tick(6);
    check("rearm_wait", 4'(armed), 4'd0);
    tick(1);
    check("rearm_done", 4'(armed), 4'd1);
    btn_raw = 4'b0001;
    tick(7);
    check("rearm_win", btn_out, 4'b0001);

    // Reset mid-LOCKED
    rst = 1'b1; tick(1);
    check("rst_locked_btn", btn_out, 4'b0000);
    check("rst_locked_inv", 4'(invalid), 4'd1);
    rst = 1'b0; btn_raw = 4'b0000;
    tick(1);

    // Lock timeout instance
    arm1 = 1'b1; tick(1); arm1 = 1'b0;
    check("l_armed", 4'(armed1), 4'd1);
    btn_raw1 = 4'b1000;
    tick(7);
    check("l_win", btn_out1, 4'b1000);
    tick(4);
    check("l_hold_last", btn_out1, 4'b1000);
    tick(1);
    check("l_timeout_btn", btn_out1, 4'b0000);
    check("l_timeout_inv", 4'(invalid1), 4'd1);
    check("l_timeout_armed", 4'(armed1), 4'd0);
    btn_raw1 = 4'b0000;
    tick(6);
    check("l_rearm_wait", 4'(armed1), 4'd0);
    tick(1);
    check("l_rearm_done", 4'(armed1), 4'd1);
    btn_raw1 = 4'b1000;
    tick(7);
    check("l_win2", btn_out1, 4'b1000);
    tick(2);
    clear1 = 1'b1; tick(1); clear1 = 1'b0;
    check("l_clear_btn", btn_out1, 4'b0000);
    check("l_clear_locked", 4'(locked1), 4'd0);
    tick(5);
    check("l_idle_stays", 4'(armed1), 4'd0);
    check("l_idle_inv", 4'(invalid1), 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
